// File: rtl/mul4_seq_pkg.sv
// Shared state encoding and ALU opcodes for the sequential 4x4 multiplier.
package mul4_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ABSA   = 3'd1,
        S_ABSB   = 3'd2,
        S_RUN    = 3'd3,
        S_NEG_LO = 3'd4,
        S_NEG_HI = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_NEG = 2'b11;

endpackage

// File: rtl/mul4_seq_alu.sv
// 4-bit ALU: logic ops when arit=0, add/sub/increment/negate when arit=1.
module alu (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       arit,
    input  logic [1:0] ALUOp,
    output logic [3:0] R,
    output logic       carry,
    output logic       zero,
    output logic       sign
);
    logic [4:0] w_sum;
    logic [3:0] w_x;
    logic [3:0] w_y;
    logic       w_cin;

    // Every arithmetic op is one 5-bit add: A-side, B-side and carry-in vary.
    always_comb begin
        w_x   = A;
        w_y   = B;
        w_cin = 1'b0;
        case (ALUOp)
            2'b00: begin w_x = A;    w_y = B;    w_cin = 1'b0; end
            2'b01: begin w_x = A;    w_y = ~B;   w_cin = 1'b1; end
            2'b10: begin w_x = A;    w_y = 4'h0; w_cin = 1'b1; end
            default: begin w_x = 4'h0; w_y = ~B; w_cin = 1'b1; end
        endcase
    end

    assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {4'h0, w_cin};

    always_comb begin
        R     = 4'h0;
        carry = 1'b0;
        if (arit) begin
            R     = w_sum[3:0];
            carry = w_sum[4];
        end else begin
            case (ALUOp)
                2'b00:   R = A & B;
                2'b01:   R = A | B;
                2'b10:   R = A ^ B;
                default: R = ~A;
            endcase
        end
    end

    assign zero = (R == 4'h0);
    assign sign = R[3];

endmodule

// File: rtl/mul4_seq.sv
// Sequential 4x4 shift-and-add multiplier (unsigned or signed) that uses the
// shared 4-bit alu as its only adder; start/busy/done handshake.
module mul4_seq
    import mul4_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       sgn,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [7:0] P,
    output logic       busy,
    output logic       done,
    output logic       zero
);
    state_t     r_state, w_state_next;
    logic [3:0] r_m, w_m_next;
    logic [3:0] r_h, w_h_next;
    logic [3:0] r_l, w_l_next;
    logic [1:0] r_cnt, w_cnt_next;
    logic       r_neg, w_neg_next;
    logic       r_neg_c, w_neg_c_next;
    logic       r_sgn, w_sgn_next;
    logic       r_zero;

    logic [3:0] w_alu_a;
    logic [3:0] w_alu_b;
    logic [1:0] w_alu_op;
    logic [3:0] w_alu_r;
    logic       w_alu_carry;

    alu u_alu (
        .A     (w_alu_a),
        .B     (w_alu_b),
        .arit  (1'b1),
        .ALUOp (w_alu_op),
        .R     (w_alu_r),
        .carry (w_alu_carry),
        .zero  (),
        .sign  ()
    );

    always_comb begin
        w_state_next = r_state;
        w_m_next     = r_m;
        w_h_next     = r_h;
        w_l_next     = r_l;
        w_cnt_next   = r_cnt;
        w_neg_next   = r_neg;
        w_neg_c_next = r_neg_c;
        w_sgn_next   = r_sgn;
        w_alu_a      = 4'h0;
        w_alu_b      = 4'h0;
        w_alu_op     = ALU_ADD;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_m_next     = A;
                    w_l_next     = B;
                    w_h_next     = 4'h0;
                    w_cnt_next   = 2'd0;
                    w_neg_next   = sgn & (A[3] ^ B[3]);
                    w_sgn_next   = sgn;
                    w_state_next = sgn ? S_ABSA : S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_ABSA: begin
                if (r_m[3]) begin
                    w_alu_b  = r_m;
                    w_alu_op = ALU_NEG;
                    w_m_next = w_alu_r;
                end
                w_state_next = S_ABSB;
            end
            S_ABSB: begin
                if (r_l[3]) begin
                    w_alu_b  = r_l;
                    w_alu_op = ALU_NEG;
                    w_l_next = w_alu_r;
                end
                w_state_next = S_RUN;
            end
            S_RUN: begin
                // Shift right by one each step; the ALU sum enters from the top.
                if (r_l[0]) begin
                    w_alu_a              = r_h;
                    w_alu_b              = r_m;
                    {w_h_next, w_l_next} = {w_alu_carry, w_alu_r, r_l[3:1]};
                end else begin
                    {w_h_next, w_l_next} = {1'b0, r_h, r_l[3:1]};
                end
                w_cnt_next = r_cnt + 2'd1;
                if (r_cnt == 2'd3)
                    w_state_next = r_sgn ? S_NEG_LO : S_DONE;
            end
            S_NEG_LO: begin
                if (r_neg) begin
                    w_alu_b      = r_l;
                    w_alu_op     = ALU_NEG;
                    w_l_next     = w_alu_r;
                    w_neg_c_next = w_alu_carry;
                end
                w_state_next = S_NEG_HI;
            end
            S_NEG_HI: begin
                // Low-nibble borrow decides between full negate and plain invert.
                if (r_neg) begin
                    if (r_neg_c) begin
                        w_alu_b  = r_h;
                        w_alu_op = ALU_NEG;
                        w_h_next = w_alu_r;
                    end else begin
                        w_h_next = ~r_h;
                    end
                end
                w_state_next = S_DONE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_m     <= 4'h0;
            r_h     <= 4'h0;
            r_l     <= 4'h0;
            r_cnt   <= 2'd0;
            r_neg   <= 1'b0;
            r_neg_c <= 1'b0;
            r_sgn   <= 1'b0;
            r_zero  <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_m     <= w_m_next;
            r_h     <= w_h_next;
            r_l     <= w_l_next;
            r_cnt   <= w_cnt_next;
            r_neg   <= w_neg_next;
            r_neg_c <= w_neg_c_next;
            r_sgn   <= w_sgn_next;
            r_zero  <= ({w_h_next, w_l_next} == 8'h00);
        end
    end

    assign P    = {r_h, r_l};
    assign zero = r_zero;
    assign busy = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_mul4_seq.sv
// Directed self-checking bench for mul4_seq with hand-computed products.
module tb_mul4_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       sgn = 1'b0;
    logic [3:0] A = 4'h0;
    logic [3:0] B = 4'h0;
    logic [7:0] P;
    logic       busy;
    logic       done;
    logic       zero;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mul4_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sgn   (sgn),
        .A     (A),
        .B     (B),
        .P     (P),
        .busy  (busy),
        .done  (done),
        .zero  (zero)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue start now (1ns after an edge), wait for done, check latency/P/zero.
    task automatic mul(input string tag, input logic s, input logic [3:0] a,
                       input logic [3:0] b, input logic [7:0] exp_p,
                       input logic exp_z, input int lat);
        int n;
        start = 1'b1; sgn = s; A = a; B = b;
        tick();
        start = 1'b0; A = 4'h0; B = 4'h0;
        chk({tag, "_busy1"}, int'(busy), 1);
        n = 1;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_P"}, int'(P), int'(exp_p));
        chk({tag, "_zero"}, int'(zero), int'(exp_z));
        $display("txn %s sgn=%0d A=%h B=%h -> P=%h zero=%0d cycles=%0d",
                 tag, s, a, b, P, zero, n);
    endtask

    initial begin
        // Reset with start held high
        start = 1'b1; A = 4'h3; B = 4'h3;
        #2;
        tick(); tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_P", int'(P), 8'h00);
        chk("rst_zero", int'(zero), 1);
        start = 1'b0;
        rst_n = 1'b1;
        tick(); tick();
        chk("idle_busy", int'(busy), 0);
        chk("idle_done", int'(done), 0);

        mul("u13x11", 1'b0, 4'hD, 4'hB, 8'h8F, 1'b0, 5);
        tick();
        chk("idle_after_done", int'(done), 0);
        chk("idle_hold_P", int'(P), 8'h8F);

        mul("u0x9", 1'b0, 4'h0, 4'h9, 8'h00, 1'b1, 5);
        mul("u15x15_b2b", 1'b0, 4'hF, 4'hF, 8'hE1, 1'b0, 5);

        mul("sm3x5", 1'b1, 4'hD, 4'h5, 8'hF1, 1'b0, 9);
        mul("sm8xm8", 1'b1, 4'h8, 4'h8, 8'h40, 1'b0, 9);
        mul("s4xm2", 1'b1, 4'h4, 4'hE, 8'hF8, 1'b0, 9);
        mul("sm8x7", 1'b1, 4'h8, 4'h7, 8'hC8, 1'b0, 9);
        mul("u7x7_s", 1'b0, 4'h7, 4'h7, 8'h31, 1'b0, 5);
        tick();

        // start pulsed during RUN must be ignored
        start = 1'b1; sgn = 1'b0; A = 4'h7; B = 4'h7;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; sgn = 1'b1; A = 4'h1; B = 4'h1;
        tick();
        start = 1'b0;
        chk("midrun_busy", int'(busy), 1);
        tick(); tick();
        chk("midrun_done", int'(done), 1);
        chk("midrun_P", int'(P), 8'h31);
        $display("txn midrun_ignore A=7 B=7 -> P=%h", P);
        tick();

        // asynchronous reset mid-RUN
        start = 1'b1; sgn = 1'b0; A = 4'h5; B = 4'h6;
        tick();
        start = 1'b0;
        tick();
        #3 rst_n = 1'b0;
        #1;
        chk("arst_P", int'(P), 8'h00);
        chk("arst_busy", int'(busy), 0);
        chk("arst_zero", int'(zero), 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("arst_nodone", int'(done), 0);
        end
        rst_n = 1'b1;
        tick();
        $display("txn reset_midrun -> P=%h busy=%0d", P, busy);
        mul("u2x3", 1'b0, 4'h2, 4'h3, 8'h06, 1'b0, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
